// File: rtl/multi_source_reg_pkg.sv
// rtl/multi_source_reg_pkg.sv - shared encodings and helpers for multi_source_reg_bank
package multi_source_reg_pkg;

    localparam int MODE_A_PRIO = 0;
    localparam int MODE_B_PRIO = 1;
    localparam int MODE_ALT    = 2;

    // Saturating add with one guard bit so the sum cannot wrap before the limit compare
    function automatic logic [63:0] sat_add(
        input logic [63:0] cnt,
        input logic [63:0] inc,
        input int unsigned cnt_w
    );
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, cnt} + {1'b0, inc};
        lim = (65'd1 << cnt_w) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/msrb_channel.sv
// rtl/msrb_channel.sv - one arbitrated register channel with turn bit, sticky flag and update pulse
module msrb_channel
    import multi_source_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1,
    parameter int               MODE    = MODE_A_PRIO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_a,
    input  logic [WIDTH-1:0] da,
    input  logic             wr_b,
    input  logic [WIDTH-1:0] db,
    input  logic             clr,
    input  logic             set,
    input  logic             coll_clr,
    output logic [WIDTH-1:0] q,
    output logic             q_upd,
    output logic             coll_sticky,
    output logic             coll
);

    logic turn;
    logic b_wins;

    assign coll   = wr_a & wr_b;
    // turn = 0 means source A owns the next collision in alternating mode
    assign b_wins = (MODE == MODE_B_PRIO) ? 1'b1 :
                    (MODE == MODE_ALT)    ? turn : 1'b0;

    // Single driver for all channel state: clr > set > write > hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q           <= RST_VAL;
            q_upd       <= 1'b0;
            coll_sticky <= 1'b0;
            turn        <= 1'b0;
        end else begin
            q_upd <= clr | set | wr_a | wr_b;

            if (clr)
                q <= '0;
            else if (set)
                q <= SET_VAL;
            else if (coll)
                q <= b_wins ? db : da;
            else if (wr_a)
                q <= da;
            else if (wr_b)
                q <= db;

            // The turn advances on every collision, even when clr/set mask the write
            if (coll)
                turn <= ~turn;

            // A fresh collision beats a simultaneous clear of the flag
            if (coll)
                coll_sticky <= 1'b1;
            else if (coll_clr)
                coll_sticky <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_source_reg_bank.sv
// rtl/multi_source_reg_bank.sv - bank of arbitrated registers with collision tracking
module multi_source_reg_bank
    import multi_source_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               NCH     = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1,
    parameter int               MODE    = MODE_A_PRIO,
    parameter int               CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       wr_a,
    input  logic [NCH*WIDTH-1:0] da,
    input  logic [NCH-1:0]       wr_b,
    input  logic [NCH*WIDTH-1:0] db,
    input  logic [NCH-1:0]       clr,
    input  logic [NCH-1:0]       set,
    input  logic                 coll_clr,
    output logic [NCH*WIDTH-1:0] q,
    output logic [NCH-1:0]       q_upd,
    output logic [NCH-1:0]       coll_sticky,
    output logic [CNT_W-1:0]     coll_cnt
);

    localparam int PC_W = $clog2(NCH + 1);

    logic [NCH-1:0]   coll;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        msrb_channel #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL),
            .SET_VAL (SET_VAL),
            .MODE    (MODE)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .wr_a        (wr_a[i]),
            .da          (da[i*WIDTH +: WIDTH]),
            .wr_b        (wr_b[i]),
            .db          (db[i*WIDTH +: WIDTH]),
            .clr         (clr[i]),
            .set         (set[i]),
            .coll_clr    (coll_clr),
            .q           (q[i*WIDTH +: WIDTH]),
            .q_upd       (q_upd[i]),
            .coll_sticky (coll_sticky[i]),
            .coll        (coll[i])
        );
    end

    // Number of channels colliding this cycle
    always_comb begin
        pc = '0;
        for (int i = 0; i < NCH; i++)
            pc = pc + PC_W'(coll[i]);
    end

    // coll_clr restarts from zero but still counts this cycle's collisions
    assign cnt_base = coll_clr ? '0 : coll_cnt;
    assign cnt_next = CNT_W'(sat_add(64'(cnt_base), 64'(pc), CNT_W));

    // Global saturating collision counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            coll_cnt <= '0;
        else
            coll_cnt <= cnt_next;
    end

endmodule

// File: tb/tb_multi_source_reg_bank.sv
// tb/tb_multi_source_reg_bank.sv - self-checking bench for multi_source_reg_bank
module tb_multi_source_reg_bank;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 4;
    localparam logic [W-1:0] RV = 8'h5A;
    localparam logic [W-1:0] SV = 8'hFF;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   wr_a, wr_b, clr, set;
    logic [N*W-1:0] da, db;
    logic           coll_clr;
    logic [N*W-1:0] q;
    logic [N-1:0]   q_upd, coll_sticky;
    logic [CW-1:0]  coll_cnt;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq [N];
    logic [N-1:0] mupd, mst, mturn;
    int           mcnt;

    multi_source_reg_bank #(
        .WIDTH(W), .NCH(N), .RST_VAL(RV), .SET_VAL(SV), .MODE(2), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .wr_a(wr_a), .da(da), .wr_b(wr_b), .db(db),
        .clr(clr), .set(set), .coll_clr(coll_clr), .q(q), .q_upd(q_upd),
        .coll_sticky(coll_sticky), .coll_cnt(coll_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_a = '0; wr_b = '0; clr = '0; set = '0; coll_clr = 1'b0;
        da = '0; db = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i] = RV;
        mupd = '0; mst = '0; mturn = '0; mcnt = 0;
    endtask

    // Reference behaviour for one rising edge, from the current inputs
    task automatic model_edge();
        int n;
        n = 0;
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] a, b;
            logic both, use_b;
            a = da[i*W +: W];
            b = db[i*W +: W];
            both = wr_a[i] && wr_b[i];
            use_b = mturn[i];
            mupd[i] = clr[i] || set[i] || wr_a[i] || wr_b[i];
            if (both) begin
                n++;
                mturn[i] = ~mturn[i];
                mst[i] = 1'b1;
            end else if (coll_clr) begin
                mst[i] = 1'b0;
            end
            if (clr[i])       mq[i] = '0;
            else if (set[i])  mq[i] = SV;
            else if (both)    mq[i] = use_b ? b : a;
            else if (wr_a[i]) mq[i] = a;
            else if (wr_b[i]) mq[i] = b;
        end
        mcnt = (coll_clr ? 0 : mcnt) + n;
        if (mcnt > (1 << CW) - 1) mcnt = (1 << CW) - 1;
    endtask

    task automatic compare_all();
        logic [N*W-1:0] e;
        for (int i = 0; i < N; i++) e[i*W +: W] = mq[i];
        chk("q", 64'(q), 64'(e));
        chk("q_upd", 64'(q_upd), 64'(mupd));
        chk("coll_sticky", 64'(coll_sticky), 64'(mst));
        chk("coll_cnt", 64'(coll_cnt), 64'(mcnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        idle();
        #1 rst = 1'b1;
        model_reset();
        #12;
        compare_all();
        @(negedge clk) rst = 1'b0;
        #1;
        chk("reset_q", 64'(q), 64'h5A5A5A5A);
        chk("reset_cnt", 64'(coll_cnt), 64'd0);

        // Channel 0 single-source writes
        @(negedge clk);
        wr_a = 4'b0001; da = 32'h00000011;
        tick();
        chk("ch0_a_q", 64'(q[7:0]), 64'h11);
        chk("ch0_a_upd", 64'(q_upd[0]), 64'd1);
        idle();
        tick();
        chk("ch0_upd_pulse", 64'(q_upd[0]), 64'd0);
        wr_b = 4'b0001; db = 32'h00000022;
        tick();
        chk("ch0_b_q", 64'(q[7:0]), 64'h22);

        // Alternating collisions on channel 1
        idle();
        wr_a = 4'b0010; wr_b = 4'b0010; da = {4{8'hAA}}; db = {4{8'hBB}};
        tick(); chk("alt_1", 64'(q[15:8]), 64'hAA);
        tick(); chk("alt_2", 64'(q[15:8]), 64'hBB);
        tick(); chk("alt_3", 64'(q[15:8]), 64'hAA);
        chk("alt_sticky", 64'(coll_sticky[1]), 64'd1);
        chk("alt_cnt", 64'(coll_cnt), 64'd3);

        // Clear everything, then clr/set/write together on channel 2
        idle(); coll_clr = 1'b1;
        tick();
        chk("cclr_cnt", 64'(coll_cnt), 64'd0);
        idle();
        clr = 4'b0100; set = 4'b0100; wr_a = 4'b0100; da = 32'h00330000;
        tick();
        chk("prio_q", 64'(q[23:16]), 64'h00);
        chk("prio_upd", 64'(q_upd[2]), 64'd1);
        wr_b = 4'b0100; db = 32'h00440000;
        tick();
        chk("prio_coll_cnt", 64'(coll_cnt), 64'd1);
        chk("prio_coll_q", 64'(q[23:16]), 64'h00);

        // Counter saturation then clear with simultaneous collisions
        idle(); coll_clr = 1'b1;
        tick();
        idle();
        wr_a = 4'b1111; wr_b = 4'b1111;
        da = $urandom; db = $urandom;
        repeat (4) tick();
        chk("sat_cnt", 64'(coll_cnt), 64'd15);
        wr_a = 4'b0011; wr_b = 4'b0011; coll_clr = 1'b1;
        tick();
        chk("clr_coll_cnt", 64'(coll_cnt), 64'd2);
        chk("clr_coll_sticky", 64'(coll_sticky), 64'b0011);

        // Asynchronous reset in the middle of a write
        idle(); wr_a = 4'b1111; da = $urandom;
        tick();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_q", 64'(q), 64'h5A5A5A5A);
        chk("async_upd", 64'(q_upd), 64'd0);
        chk("async_cnt", 64'(coll_cnt), 64'd0);
        idle(); wr_a = 4'b0001; da = 32'h00000077;
        @(negedge clk) rst = 1'b0;
        tick();
        chk("post_rst_q", 64'(q[7:0]), 64'h77);

        // Randomised traffic against the model
        repeat (300) begin
            wr_a = 4'($urandom); wr_b = 4'($urandom);
            clr = 4'($urandom & $urandom & $urandom);
            set = 4'($urandom & $urandom);
            coll_clr = ($urandom_range(0, 7) == 0);
            da = $urandom; db = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_source_reg_bank.md
Name: multi_source_reg_bank

Overview:
- Parametrised bank of NCH independent WIDTH-bit registers.
- Each register has two legal write sources (A and B) plus synchronous clear and set, all resolved by a single arbitrated driver per register.
- Replaces ad-hoc flops that were driven from several processes. Sits between control sources (e.g. CSR write path and hardware update path) and the consumers of the state.
- Reports write collisions per channel (sticky flag) and globally (saturating counter).

Parameters:
- WIDTH, 8: data width of each register.
- NCH, 4: number of channels (registers); range 1..32.
- RST_VAL, 0: value loaded into every register on reset (WIDTH bits).
- SET_VAL, all-ones: value loaded on synchronous set (WIDTH bits).
- MODE, 0: write arbitration. 0 = A wins; 1 = B wins; 2 = alternating per channel.
- CNT_W, 8: width of the global collision counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- wr_a  in  NCH  per-channel write request, source A.
- da  in  NCH*WIDTH  source A data; channel i occupies bits [i*WIDTH +: WIDTH].
- wr_b  in  NCH  per-channel write request, source B.
- db  in  NCH*WIDTH  source B data, same packing as da.
- clr  in  NCH  per-channel synchronous clear to 0.
- set  in  NCH  per-channel synchronous set to SET_VAL.
- coll_clr  in  1  clears all sticky flags and the collision counter.
- q  out  NCH*WIDTH  register contents.
- q_upd  out  NCH  one-cycle pulse: the channel's register was loaded on the previous edge.
- coll_sticky  out  NCH  per-channel sticky collision flag.
- coll_cnt  out  CNT_W  saturating count of collision events.

Behaviour:
- Reset (async, while rst=1):
  - q = RST_VAL on every channel.
  - q_upd = 0, coll_sticky = 0, coll_cnt = 0.
  - Alternating turn bits = A.
  - Reset asserted mid-operation overrides everything immediately. The first edge after rst deasserts is processed normally.
- Per-channel priority, evaluated each rising edge: clr > set > write > hold.
  - clr and set both asserted: clr wins; result 0.
- Write resolution:
  - Only wr_a: load da slice.
  - Only wr_b: load db slice.
  - Both asserted (a collision): the winner is chosen by MODE.
    - MODE 2: the winner is the channel's turn bit, and the turn bit toggles after every collision.
    - The turn bit toggles even when clr or set suppresses the write.
- Latency: q reflects the load 1 cycle after the request edge. There is no combinational path from inputs to q.
- q_upd[i]: registered; equals 1 in the cycle after any load (clr, set or write) of channel i. Set even if the loaded value equals the old value.
- Collision: wr_a[i] & wr_b[i] in the same cycle. Counted regardless of clr or set.
- coll_sticky[i]:
  - Set the cycle after a collision on channel i.
  - Held until coll_clr.
  - coll_clr and a new collision in the same cycle: the flag ends at 1.
- coll_cnt:
  - Each edge adds the number of channels colliding that cycle (popcount, 0..NCH).
  - Saturates at 2^CNT_W-1 and never wraps.
  - coll_clr in the same cycle: the counter loads that cycle's popcount rather than 0.
  - Adder is sized to avoid overflow before the saturation compare.
- Channels are fully independent apart from the shared counter.
- No X propagation: unused request bits are ignored when their req=0.

Decomposition:
- Package multi_source_reg_pkg:
  - MODE encodings as localparams: MODE_A_PRIO, MODE_B_PRIO, MODE_ALT.
  - Function for the saturating popcount add.
- One sub-module msrb_channel holds a single channel: register, priority mux, turn bit, sticky flag and q_upd. It is instantiated NCH times with a generate loop.
- The top level holds the popcount and the coll_cnt logic.

Test Plan:
- Reset with WIDTH=8, RST_VAL=8'h5A, then release -> q = 5A5A5A5A, coll_cnt=0. Asserting rst mid-write drops q to 5A without a clock edge.
- Channel 0 writes: wr_a=1, da=8'h11 -> next cycle q[7:0]=11 and q_upd[0]=1 for exactly one cycle. Then wr_b=1, db=8'h22 -> q[7:0]=22.
- MODE=2, channel 1 sees collisions on 3 consecutive cycles, da=8'hAA, db=8'hBB -> q[15:8] sequence AA, BB, AA. coll_sticky[1]=1, coll_cnt=3.
- Channel 2 with clr=1, set=1 and wr_a=1 (da=8'h33) all together -> q[23:16]=00, q_upd[2]=1. Adding wr_b=1 in the same cycle also raises coll_cnt by 1.
- CNT_W=4: collide on all 4 channels for 4 cycles -> coll_cnt=15 (saturated, not 0). Then coll_clr together with 2 channels colliding -> coll_cnt=2 and those 2 sticky flags=1.
